// File: rtl/svc_rv_ex_mc_ctrl_if.sv
// Bundle of signals between the EX stage, the multi-cycle functional units
// and the multi-cycle op controller. The controller attaches as slave; the
// pipeline/unit side (or a testbench) attaches as master.
interface svc_rv_ex_mc_ctrl_if #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 2,
    parameter int CNT_W     = 16
);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                      op_valid_ex;
    logic [UW-1:0]             op_unit_ex;
    logic                      ex_flush;
    logic                      ex_mem_stall;
    logic [NUM_UNITS-1:0]      unit_start;
    logic [NUM_UNITS-1:0]      unit_kill;
    logic [NUM_UNITS-1:0]      unit_done;
    logic [NUM_UNITS*XLEN-1:0] unit_result;
    logic                      op_active_ex;
    logic                      result_valid;
    logic [XLEN-1:0]           result;
    logic [CNT_W-1:0]          busy_cycles;

    modport master (
        output op_valid_ex, op_unit_ex, ex_flush, ex_mem_stall,
        output unit_done, unit_result,
        input  unit_start, unit_kill, op_active_ex, result_valid,
        input  result, busy_cycles
    );

    modport slave (
        input  op_valid_ex, op_unit_ex, ex_flush, ex_mem_stall,
        input  unit_done, unit_result,
        output unit_start, unit_kill, op_active_ex, result_valid,
        output result, busy_cycles
    );
endinterface

// File: rtl/svc_rv_ex_mc_ctrl.sv
// Multi-cycle op controller for the EX stage: launches one functional unit,
// stalls the pipeline while it runs, captures its result and holds it in
// DONE until EX/MEM accepts it, so the instruction is never restarted.
module svc_rv_ex_mc_ctrl #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 2,
    parameter int CNT_W     = 16
) (
    input logic                clk,
    input logic                rst_n,
    svc_rv_ex_mc_ctrl_if.slave bus
);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    // One extra bit so the unit count itself is representable for the range check.
    localparam logic [UW:0]      UNIT_LIMIT = (UW + 1)'(NUM_UNITS);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t               state_reg, state_next;
    logic [UW-1:0]        unit_reg;
    logic [XLEN-1:0]      result_reg;
    logic [CNT_W-1:0]     busy_reg;
    logic [CNT_W-1:0]     cnt_reg;

    logic [NUM_UNITS-1:0] unit_sel;
    logic [NUM_UNITS-1:0] start_vec;
    logic [NUM_UNITS-1:0] kill_vec;
    logic                 active;
    logic                 res_valid;
    logic                 launch;
    logic                 capture;
    logic                 done_hit;
    logic [XLEN-1:0]      result_sel;
    logic [XLEN-1:0]      result_masked [NUM_UNITS];

    // Decode the latched unit once; done detection and the result mux both use it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign unit_sel[gi]      = (unit_reg == UW'(gi));
            assign result_masked[gi] = unit_sel[gi] ? bus.unit_result[gi*XLEN +: XLEN] : '0;
        end
    endgenerate

    assign done_hit = |(bus.unit_done & unit_sel);

    // AND-OR result mux over the per-unit masked results.
    always_comb begin
        result_sel = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            result_sel = result_sel | result_masked[i];
        end
    end

    // Next-state and output decode; all pulses are forced low while in reset.
    always_comb begin
        state_next = state_reg;
        start_vec  = '0;
        kill_vec   = '0;
        active     = 1'b0;
        res_valid  = 1'b0;
        launch     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.op_valid_ex && !bus.ex_flush &&
                    ({1'b0, bus.op_unit_ex} < UNIT_LIMIT)) begin
                    start_vec  = NUM_UNITS'(1) << bus.op_unit_ex;
                    active     = 1'b1;
                    launch     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                active = 1'b1;
                // A flush beats a completion arriving in the same cycle.
                if (bus.ex_flush) begin
                    kill_vec   = unit_sel;
                    state_next = IDLE;
                end else if (done_hit) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (!bus.ex_mem_stall || bus.ex_flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!rst_n) begin
            start_vec = '0;
            kill_vec  = '0;
            active    = 1'b0;
            res_valid = 1'b0;
            launch    = 1'b0;
            capture   = 1'b0;
        end
    end

    // State, latched unit, cycle counter and captured result/latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            unit_reg   <= '0;
            result_reg <= '0;
            busy_reg   <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            // cnt_reg equals the cycle index since the start pulse (saturating).
            if (launch) begin
                unit_reg <= bus.op_unit_ex;
                cnt_reg  <= CNT_W'(1);
            end else if (state_reg == EXEC && cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (capture) begin
                result_reg <= result_sel;
                busy_reg   <= cnt_reg;
            end
        end
    end

    assign bus.unit_start   = start_vec;
    assign bus.unit_kill    = kill_vec;
    assign bus.op_active_ex = active;
    assign bus.result_valid = res_valid;
    assign bus.result       = result_reg;
    assign bus.busy_cycles  = busy_reg;

endmodule

// File: tb/tb_svc_rv_ex_mc_ctrl.sv
// Directed bench for the multi-cycle EX controller: a 2-unit/16-bit-counter
// instance and a 3-unit/4-bit-counter instance, with scoreboards of expected
// captured results checked whenever result_valid rises.
module tb_svc_rv_ex_mc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    svc_rv_ex_mc_ctrl_if #(.XLEN(32), .NUM_UNITS(2), .CNT_W(16)) bus_a ();
    svc_rv_ex_mc_ctrl_if #(.XLEN(32), .NUM_UNITS(3), .CNT_W(4))  bus_b ();

    svc_rv_ex_mc_ctrl #(.XLEN(32), .NUM_UNITS(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    svc_rv_ex_mc_ctrl #(.XLEN(32), .NUM_UNITS(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    typedef struct packed {
        logic [31:0] res;
        logic [15:0] busy;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic rv_a_d = 1'b0;
    logic rv_b_d = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard for instance A: pop one expectation per rising result_valid.
    always @(negedge clk) begin
        if (bus_a.result_valid && !rv_a_d) begin
            n_cmp++;
            assert (q_a.size() > 0) else begin
                n_err++;
                $error("FAIL sb_a_unexpected observed=%0h expected=none", bus_a.result);
            end
            if (q_a.size() > 0) begin
                exp_t e;
                e = q_a.pop_front();
                chk("sb_a_result", 64'(bus_a.result), 64'(e.res));
                chk("sb_a_busy", 64'(bus_a.busy_cycles), 64'(e.busy));
            end
        end
        rv_a_d <= bus_a.result_valid;
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        if (bus_b.result_valid && !rv_b_d) begin
            n_cmp++;
            assert (q_b.size() > 0) else begin
                n_err++;
                $error("FAIL sb_b_unexpected observed=%0h expected=none", bus_b.result);
            end
            if (q_b.size() > 0) begin
                exp_t e;
                e = q_b.pop_front();
                chk("sb_b_result", 64'(bus_b.result), 64'(e.res));
                chk("sb_b_busy", 64'(bus_b.busy_cycles), 64'(e.busy));
            end
        end
        rv_b_d <= bus_b.result_valid;
    end

    initial begin
        bus_a.op_valid_ex = 1'b0; bus_a.op_unit_ex = '0; bus_a.ex_flush = 1'b0;
        bus_a.ex_mem_stall = 1'b0; bus_a.unit_done = '0; bus_a.unit_result = '0;
        bus_b.op_valid_ex = 1'b0; bus_b.op_unit_ex = '0; bus_b.ex_flush = 1'b0;
        bus_b.ex_mem_stall = 1'b0; bus_b.unit_done = '0; bus_b.unit_result = '0;

        // Reset: an op presented during reset must not start anything.
        cyc();
        bus_a.op_valid_ex = 1'b1; bus_a.op_unit_ex = 1'b1;
        cyc();
        mid();
        chk("rst_start", 64'(bus_a.unit_start), 64'd0);
        chk("rst_kill", 64'(bus_a.unit_kill), 64'd0);
        chk("rst_active", 64'(bus_a.op_active_ex), 64'd0);
        chk("rst_rv", 64'(bus_a.result_valid), 64'd0);
        chk("rst_result", 64'(bus_a.result), 64'd0);
        chk("rst_busy", 64'(bus_a.busy_cycles), 64'd0);
        cyc();
        rst_n = 1'b1; bus_a.op_valid_ex = 1'b0;
        mid();
        chk("post_rst_active", 64'(bus_a.op_active_ex), 64'd0);

        // Basic op on unit 1, done at cycle 3.
        cyc();
        bus_a.op_valid_ex = 1'b1; bus_a.op_unit_ex = 1'b1;
        q_a.push_back({32'hDEADBEEF, 16'd3});
        mid();
        chk("t1_start", 64'(bus_a.unit_start), 64'h2);
        chk("t1_active0", 64'(bus_a.op_active_ex), 64'd1);
        for (int c = 1; c < 3; c++) begin
            cyc();
            mid();
            chk("t1_start_exec", 64'(bus_a.unit_start), 64'd0);
            chk("t1_active_exec", 64'(bus_a.op_active_ex), 64'd1);
        end
        cyc();
        bus_a.unit_done = 2'b10; bus_a.unit_result[32 +: 32] = 32'hDEADBEEF;
        mid();
        chk("t1_active3", 64'(bus_a.op_active_ex), 64'd1);
        chk("t1_rv3", 64'(bus_a.result_valid), 64'd0);
        cyc();
        bus_a.unit_done = '0; bus_a.op_valid_ex = 1'b0;
        mid();
        chk("t1_rv4", 64'(bus_a.result_valid), 64'd1);
        chk("t1_active4", 64'(bus_a.op_active_ex), 64'd0);
        chk("t1_start4", 64'(bus_a.unit_start), 64'd0);
        chk("t1_result4", 64'(bus_a.result), 64'hDEADBEEF);
        chk("t1_busy4", 64'(bus_a.busy_cycles), 64'd3);
        cyc();
        mid();
        chk("t1_rv5", 64'(bus_a.result_valid), 64'd0);

        // Same op with EX/MEM stalled for cycles 4-6; instruction stays in EX.
        cyc();
        bus_a.op_valid_ex = 1'b1; bus_a.op_unit_ex = 1'b1;
        q_a.push_back({32'h12345678, 16'd3});
        mid();
        chk("t2_start", 64'(bus_a.unit_start), 64'h2);
        for (int c = 1; c < 3; c++) begin
            cyc();
            mid();
        end
        cyc();
        bus_a.unit_done = 2'b10; bus_a.unit_result[32 +: 32] = 32'h12345678;
        mid();
        for (int c = 4; c < 7; c++) begin
            cyc();
            bus_a.unit_done = '0; bus_a.ex_mem_stall = 1'b1;
            bus_a.unit_result[32 +: 32] = 32'h0BAD0BAD;
            mid();
            chk("t2_rv_hold", 64'(bus_a.result_valid), 64'd1);
            chk("t2_no_restart", 64'(bus_a.unit_start), 64'd0);
            chk("t2_result_hold", 64'(bus_a.result), 64'h12345678);
        end
        cyc();
        bus_a.ex_mem_stall = 1'b0;
        mid();
        chk("t2_rv7", 64'(bus_a.result_valid), 64'd1);
        chk("t2_start7", 64'(bus_a.unit_start), 64'd0);
        chk("t2_active7", 64'(bus_a.op_active_ex), 64'd0);
        cyc();
        bus_a.op_valid_ex = 1'b0;
        mid();
        chk("t2_rv8", 64'(bus_a.result_valid), 64'd0);
        chk("t2_active8", 64'(bus_a.op_active_ex), 64'd0);

        // Flush at cycle 2 coinciding with unit_done[0]: kill wins.
        cyc();
        bus_a.op_valid_ex = 1'b1; bus_a.op_unit_ex = 1'b0;
        mid();
        chk("t3_start", 64'(bus_a.unit_start), 64'h1);
        cyc();
        mid();
        cyc();
        bus_a.ex_flush = 1'b1; bus_a.unit_done = 2'b01;
        bus_a.unit_result[0 +: 32] = 32'hAAAA5555;
        mid();
        chk("t3_kill", 64'(bus_a.unit_kill), 64'h1);
        chk("t3_start2", 64'(bus_a.unit_start), 64'd0);
        cyc();
        bus_a.ex_flush = 1'b0; bus_a.unit_done = '0; bus_a.op_valid_ex = 1'b0;
        mid();
        chk("t3_active3", 64'(bus_a.op_active_ex), 64'd0);
        chk("t3_kill3", 64'(bus_a.unit_kill), 64'd0);
        chk("t3_rv3", 64'(bus_a.result_valid), 64'd0);
        chk("t3_result_kept", 64'(bus_a.result), 64'h12345678);
        chk("t3_busy_kept", 64'(bus_a.busy_cycles), 64'd3);

        // Unit 0 active; stray done from unit 1 at cycle 2, real done at cycle 5.
        cyc();
        bus_a.op_valid_ex = 1'b1; bus_a.op_unit_ex = 1'b0;
        q_a.push_back({32'hCAFEF00D, 16'd5});
        mid();
        chk("t4_start", 64'(bus_a.unit_start), 64'h1);
        cyc();
        mid();
        cyc();
        bus_a.unit_done = 2'b10; bus_a.unit_result[32 +: 32] = 32'hBAD0BAD0;
        mid();
        chk("t4_active2", 64'(bus_a.op_active_ex), 64'd1);
        cyc();
        bus_a.unit_done = '0;
        mid();
        chk("t4_active3", 64'(bus_a.op_active_ex), 64'd1);
        chk("t4_rv3", 64'(bus_a.result_valid), 64'd0);
        cyc();
        mid();
        cyc();
        bus_a.unit_done = 2'b01; bus_a.unit_result[0 +: 32] = 32'hCAFEF00D;
        mid();
        cyc();
        bus_a.unit_done = '0; bus_a.op_valid_ex = 1'b0;
        mid();
        chk("t4_rv6", 64'(bus_a.result_valid), 64'd1);
        chk("t4_busy6", 64'(bus_a.busy_cycles), 64'd5);
        chk("t4_result6", 64'(bus_a.result), 64'hCAFEF00D);
        cyc();
        mid();
        chk("t4_rv7", 64'(bus_a.result_valid), 64'd0);

        // Instance B: out-of-range unit, then valid start, then reset mid-op.
        cyc();
        bus_b.op_valid_ex = 1'b1; bus_b.op_unit_ex = 2'd3;
        mid();
        chk("t5_oor_start", 64'(bus_b.unit_start), 64'd0);
        chk("t5_oor_active", 64'(bus_b.op_active_ex), 64'd0);
        cyc();
        bus_b.op_unit_ex = 2'd2;
        mid();
        chk("t5_start", 64'(bus_b.unit_start), 64'h4);
        chk("t5_active", 64'(bus_b.op_active_ex), 64'd1);
        cyc();
        bus_b.op_valid_ex = 1'b0;
        mid();
        cyc();
        rst_n = 1'b0; bus_b.ex_flush = 1'b1;
        mid();
        chk("t5_rst_kill", 64'(bus_b.unit_kill), 64'd0);
        chk("t5_rst_active", 64'(bus_b.op_active_ex), 64'd0);
        chk("t5_rst_start", 64'(bus_b.unit_start), 64'd0);
        chk("t5_rst_rv", 64'(bus_b.result_valid), 64'd0);
        cyc();
        rst_n = 1'b1; bus_b.ex_flush = 1'b0;
        bus_b.op_valid_ex = 1'b1; bus_b.op_unit_ex = 2'd0;
        q_b.push_back({32'h11223344, 16'd15});
        mid();
        chk("t5_idle_start", 64'(bus_b.unit_start), 64'h1);
        chk("t5_idle_kill", 64'(bus_b.unit_kill), 64'd0);
        chk("t5_idle_result", 64'(bus_b.result), 64'd0);
        chk("t5_idle_busy", 64'(bus_b.busy_cycles), 64'd0);

        // Completion 20 cycles after start saturates a 4-bit counter at 15.
        for (int c = 1; c < 20; c++) begin
            cyc();
            bus_b.op_valid_ex = 1'b0;
            mid();
        end
        cyc();
        bus_b.unit_done = 3'b001; bus_b.unit_result[0 +: 32] = 32'h11223344;
        mid();
        chk("t6_active20", 64'(bus_b.op_active_ex), 64'd1);
        cyc();
        bus_b.unit_done = '0;
        mid();
        chk("t6_rv21", 64'(bus_b.result_valid), 64'd1);
        chk("t6_busy_sat", 64'(bus_b.busy_cycles), 64'd15);
        cyc();
        mid();
        chk("t6_rv22", 64'(bus_b.result_valid), 64'd0);

        // Every expected capture must have been observed.
        cyc();
        mid();
        chk("sb_a_drained", 64'(q_a.size()), 64'd0);
        chk("sb_b_drained", 64'(q_b.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/svc_rv_ex_mc_ctrl.md
SVC_RV_EX_MC_CTRL -- requirements
Module: svc_rv_ex_mc_ctrl

Interface
REQ-001 XLEN, default 32, datapath width of unit results.
REQ-002 NUM_UNITS, default 2, number of multi-cycle functional units (>=1); UW = max(1, $clog2(NUM_UNITS)).
REQ-003 CNT_W, default 16, width of the busy-cycle counter.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 op_valid_ex  in  1  multi-cycle op present in EX.
REQ-007 op_unit_ex  in  UW  target unit index for the op in EX.
REQ-008 ex_flush  in  1  kill the op in EX.
REQ-009 ex_mem_stall  in  1  EX/MEM register stalled; EX cannot advance.
REQ-010 unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse to the selected unit.
REQ-011 unit_kill  out  NUM_UNITS  one-hot, one-cycle abort pulse to the active unit.
REQ-012 unit_done  in  NUM_UNITS  per-unit one-cycle completion pulse.
REQ-013 unit_result  in  NUM_UNITS*XLEN  per-unit result; unit i at bits [i*XLEN +: XLEN].
REQ-014 op_active_ex  out  1  stall request to the hazard unit.
REQ-015 result_valid  out  1  captured result available for EX/MEM.
REQ-016 result  out  XLEN  captured result.
REQ-017 busy_cycles  out  CNT_W  latency of the last completed op.

Function
REQ-018 FSM states IDLE, EXEC, DONE; the active unit index is latched on start.
REQ-019 IDLE: op_valid_ex && !ex_flush && op_unit_ex < NUM_UNITS -> unit_start[op_unit_ex]=1, op_active_ex=1 (combinational, same cycle), latch unit, next EXEC.
REQ-020 IDLE: op_unit_ex >= NUM_UNITS -> no start, op_active_ex=0, stay IDLE.
REQ-021 EXEC: op_active_ex=1 every cycle; unit_start=0.
REQ-022 EXEC: ex_flush -> unit_kill[latched]=1 for that cycle, next IDLE, result discarded; flush wins over a simultaneous unit_done.
REQ-023 EXEC: unit_done[latched] && !ex_flush -> result <= unit_result[latched], next DONE.
REQ-024 unit_done from a non-latched unit, or any unit_done in IDLE or DONE, is ignored.
REQ-025 DONE: result_valid=1, op_active_ex=0, so the instruction advances when !ex_mem_stall.
REQ-026 DONE: !ex_mem_stall or ex_flush -> next IDLE; otherwise remain DONE with result held stable.
REQ-027 DONE exists so that the same instruction still in EX is not restarted; back-to-back ops start no earlier than the cycle after leaving DONE.
REQ-028 result_valid=0 in IDLE and EXEC; result holds its last captured value outside DONE.
REQ-029 busy_cycles is the number of clock edges from the start-pulse cycle to the done cycle (start cycle 0, done cycle N -> N); it updates at capture, saturates at 2^CNT_W-1, and is unchanged by a flushed op.
REQ-030 unit_start and unit_kill are never both nonzero in the same cycle; each has at most one bit set.

Reset
REQ-031 While rst_n=0 on a clock edge: state IDLE; result, busy_cycles, and the latched unit are 0.
REQ-032 During reset: unit_start=0, unit_kill=0, op_active_ex=0, result_valid=0; reset mid-op issues no kill pulse.
REQ-033 The first cycle after reset behaves as IDLE.

Verification
REQ-034 NUM_UNITS=2; op_valid_ex=1, unit 1 at cycle 0; unit_done[1] at cycle 3 with result 0xDEADBEEF -> unit_start=2'b10 at cycle 0 only; op_active_ex=1 for cycles 0-3; result_valid=1 and result=0xDEADBEEF at cycle 4; busy_cycles=3.
REQ-035 Same as REQ-034, plus ex_mem_stall=1 for cycles 4-6 -> DONE held for cycles 4-7, result stable, no restart; IDLE at cycle 8.
REQ-036 Unit 0 started; ex_flush at cycle 2 with unit_done[0] also at cycle 2 -> unit_kill=2'b01 at cycle 2; IDLE at cycle 3; result_valid never set; result and busy_cycles unchanged.
REQ-037 Unit 0 active; unit_done[1] pulse at cycle 2, then unit_done[0] at cycle 5 -> the cycle-2 pulse is ignored; capture at cycle 5 with busy_cycles=5.
REQ-038 NUM_UNITS=3; op_unit_ex=3 -> no start pulse and op_active_ex=0; rst_n=0 during EXEC -> IDLE next cycle, all outputs 0, no kill pulse.
REQ-039 CNT_W=4; done 20 cycles after start -> busy_cycles=15.
